// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pooling stage: signed max over non-overlapping windows of P
// elements in vectors of N elements. The last window of a vector may be partial.
module maxpool_stream #(
  parameter int N = 25,
  parameter int P = 2,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [W-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                y_last
);

  localparam int WC_W = (P > 1) ? $clog2(P) : 1;
  localparam int EC_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WC_W-1:0] WIN_MAX  = WC_W'(P - 1);
  localparam logic [EC_W-1:0] ELEM_MAX = EC_W'(N - 1);

  logic [WC_W-1:0]     win_cnt;
  logic [EC_W-1:0]     elem_cnt;
  logic signed [W-1:0] max_r;
  logic signed [W-1:0] cand;
  logic                accept;
  logic                consume;
  logic                elem_last;
  logic                win_end;

  // Single output register; a stalled result blocks new input so nothing is lost.
  assign x_ready   = !y_valid || y_ready;
  assign accept    = x_valid && x_ready;
  assign consume   = y_valid && y_ready;
  assign elem_last = (elem_cnt == ELEM_MAX);
  assign win_end   = (win_cnt == WIN_MAX) || elem_last;

  always_comb begin
    cand = x_data;
    if (win_cnt != '0 && !(x_data > max_r)) begin
      cand = max_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt  <= '0;
      elem_cnt <= '0;
      max_r    <= '0;
      y_data   <= '0;
      y_valid  <= 1'b0;
      y_last   <= 1'b0;
    end else begin
      if (accept) begin
        max_r    <= cand;
        win_cnt  <= win_end ? '0 : win_cnt + WC_W'(1);
        elem_cnt <= elem_last ? '0 : elem_cnt + EC_W'(1);
      end
      // A load in the same cycle as a consume replaces the drained result.
      if (accept && win_end) begin
        y_data  <= cand;
        y_valid <= 1'b1;
        y_last  <= elem_last;
      end else if (consume) begin
        y_valid <= 1'b0;
        y_last  <= 1'b0;
      end
    end
  end

endmodule
